// File: rtl/adder_2bit_pkg.sv
// Shared constants for the bit-serial adder: default word length and the
// helper that sizes the bit counter.
package adder_2bit_pkg;

  // Default serial frame length in bits.
  localparam int DEFAULT_WIDTH = 2;

  // Bit-counter width for a given word length.
  // The counter is never narrower than one bit, so WIDTH=1 still has a legal
  // (constant zero) counter.
  function automatic int cntWidth(input int width);
    if (width <= 1) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder used as the arithmetic core of the serial adder.
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ cin_i;
  assign co_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/adder_2bit.sv
// Bit-serial adder: one operand bit of x and y per clock, LSB first, one
// registered sum bit per clock. Words are WIDTH bits long; the carry is held
// between bits and dropped at every word boundary. word_done pulses with the
// MSB sum bit and carry_out then holds the word's final carry.
// Optional build macro ADDER_SUB_EN adds a 'sub' input that turns the word
// into a two's-complement subtract (x - y); carry_out=1 then means no borrow.
module adder_2bit
  import adder_2bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic y,
`ifdef ADDER_SUB_EN
  input  logic sub,
`endif
  output logic out,
  output logic carry_out,
  output logic word_done
);

  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          c_q;
  logic          out_q, out_d;
  logic          carry_q, carry_d;
  logic          done_q, done_d;

  logic wordStart;
  logic wordEnd;
  logic effSub;
  logic addB;
  logic addCin;
  logic sum;
  logic cout;

  assign wordStart = (cnt_q == '0);
  assign wordEnd   = (cnt_q == LAST_BIT);

`ifdef ADDER_SUB_EN
  logic sub_q;

  // Capture the operation mode on the first bit of each word so that a
  // mid-word change of 'sub' only affects the following word.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else if (wordStart) begin
      sub_q <= sub;
    end
  end

  // On the first bit the live input decides, afterwards the latched copy.
  assign effSub = wordStart ? sub : sub_q;
`else
  assign effSub = 1'b0;
`endif

  // Subtract is x + ~y + 1: invert y and inject the +1 as the first carry-in.
  assign addB   = y ^ effSub;
  assign addCin = wordStart ? effSub : c_q;

  full_adder_cell u_fa (
    .a_i   (x),
    .b_i   (addB),
    .cin_i (addCin),
    .s_o   (sum),
    .co_o  (cout)
  );

  // Next-state: advance the bit counter, register the sum bit, and publish
  // the carry together with the end-of-word pulse on the last bit.
  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    out_d   = sum;
    carry_d = carry_q;
    done_d  = 1'b0;
    if (wordEnd) begin
      cnt_d   = '0;
      carry_d = cout;
      done_d  = 1'b1;
    end
  end

  // State and output registers; reset wins over everything, including mid-word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      c_q     <= 1'b0;
      out_q   <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      c_q     <= cout;
      out_q   <= out_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign out       = out_q;
  assign carry_out = carry_q;
  assign word_done = done_q;

endmodule

// File: tb/tb_adder_2bit.sv
// Directed testbench for adder_2bit (WIDTH=2). A per-cycle vector table
// drives the corner sequences; a word-level loop then checks whole sums.
// Subtract vectors are included when built with ADDER_SUB_EN.
module tb_adder_2bit;

  logic clk;
  logic rst;
  logic x;
  logic y;
`ifdef ADDER_SUB_EN
  logic sub;
`endif
  logic out;
  logic carry_out;
  logic word_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string name;
    logic  rst;
    logic  x;
    logic  y;
    logic  sub;
    logic  eOut;
    logic  eCarry;
    logic  eDone;
  } vec_t;

  vec_t vecs[$];

  adder_2bit #(.WIDTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .y         (y),
`ifdef ADDER_SUB_EN
    .sub       (sub),
`endif
    .out       (out),
    .carry_out (carry_out),
    .word_done (word_done)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input string name, input logic r, input logic xi, input logic yi,
                        input logic si, input logic eo, input logic ec, input logic ed);
    vec_t v;
    v.name = name; v.rst = r; v.x = xi; v.y = yi; v.sub = si;
    v.eOut = eo; v.eCarry = ec; v.eDone = ed;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs at the falling edge, then step just past the
  // rising edge that samples them.
  task automatic applyStimulus(input logic r, input logic xi, input logic yi, input logic si);
    @(negedge clk);
    rst = r;
    x   = xi;
    y   = yi;
`ifdef ADDER_SUB_EN
    sub = si;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic checkBit(input string name, input string what, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s: got %b expected %b", name, what, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic eo, input logic ec, input logic ed);
    checkBit(name, "out", out, eo);
    checkBit(name, "carry_out", carry_out, ec);
    checkBit(name, "word_done", word_done, ed);
  endtask

  initial begin
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] got;
    logic [2:0] exp;

    rst = 1'b1;
    x   = 1'b0;
    y   = 1'b0;
`ifdef ADDER_SUB_EN
    sub = 1'b0;
`endif

    //       name          rst x  y  sub  out cry done
    addVec("reset0",       1, 1, 1, 0,   0,  0,  0);
    addVec("reset1",       1, 1, 1, 0,   0,  0,  0);
    addVec("1+1 b0",       0, 1, 1, 0,   0,  0,  0);
    addVec("1+1 b1",       0, 0, 0, 0,   1,  0,  1);
    addVec("3+3 b0",       0, 1, 1, 0,   0,  0,  0);
    addVec("3+3 b1",       0, 1, 1, 0,   1,  1,  1);
    addVec("0+0 b0",       0, 0, 0, 0,   0,  1,  0);
    addVec("0+0 b1",       0, 0, 0, 0,   0,  0,  1);
    addVec("mid 3+3 b0",   0, 1, 1, 0,   0,  0,  0);
    addVec("mid rst",      1, 1, 1, 0,   0,  0,  0);
    addVec("2+1 b0",       0, 0, 1, 0,   1,  0,  0);
    addVec("2+1 b1",       0, 1, 0, 0,   1,  0,  1);
    addVec("str 1+1 b0",   0, 1, 1, 0,   0,  0,  0);
    addVec("str 1+1 b1",   0, 0, 0, 0,   1,  0,  1);
    addVec("str 3+3 b0",   0, 1, 1, 0,   0,  0,  0);
    addVec("str 3+3 b1",   0, 1, 1, 0,   1,  1,  1);
    addVec("str 2+1 b0",   0, 0, 1, 0,   1,  1,  0);
    addVec("str 2+1 b1",   0, 1, 0, 0,   1,  0,  1);
`ifdef ADDER_SUB_EN
    addVec("3-1 b0",       0, 1, 1, 1,   0,  0,  0);
    addVec("3-1 b1",       0, 1, 0, 1,   1,  1,  1);
    addVec("1-2 b0",       0, 1, 0, 1,   1,  1,  0);
    addVec("1-2 b1",       0, 0, 1, 1,   1,  0,  1);
    addVec("3-1 drop b0",  0, 1, 1, 1,   0,  0,  0);
    addVec("3-1 drop b1",  0, 1, 0, 0,   1,  1,  1);
    addVec("add again b0", 0, 1, 1, 0,   0,  1,  0);
    addVec("add again b1", 0, 0, 0, 0,   1,  0,  1);
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].x, vecs[i].y, vecs[i].sub);
      checkOutput(vecs[i].name, vecs[i].eOut, vecs[i].eCarry, vecs[i].eDone);
    end

    // Whole-word sums streamed back to back: compare {carry, sum bits}
    // against the arithmetic result of the two operands.
    for (int w = 0; w < 8; w++) begin
      a = 2'($urandom_range(0, 3));
      b = 2'($urandom_range(0, 3));
      exp = {1'b0, a} + {1'b0, b};
      applyStimulus(1'b0, a[0], b[0], 1'b0);
      checkBit("word bit0", "word_done", word_done, 1'b0);
      got[0] = out;
      applyStimulus(1'b0, a[1], b[1], 1'b0);
      checkBit("word bit1", "word_done", word_done, 1'b1);
      got[1] = out;
      got[2] = carry_out;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL word %0d+%0d: got %0d expected %0d", a, b, got, exp);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_2bit.md
Name: adder_2bit

Overview:
- Bit-serial adder. Each clock it takes one operand bit of `x` and one of `y`, LSB first.
- It produces one registered sum bit per clock.
- The carry is held in a flop between bits and cleared at every word boundary; a word is WIDTH bits (default 2).
- Used as a minimal serial-arithmetic datapath cell and reports the final carry-out per word.

Parameters:
- WIDTH, 2, operand word length in bits (serial frame length); legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- x  input  1  operand A serial bit, LSB first
- y  input  1  operand B serial bit, LSB first
- out  output  1  registered sum bit
- carry_out  output  1  final carry of the completed word; valid while word_done=1
- word_done  output  1  one-cycle pulse; `out` holds the MSB sum bit of a completed word
- sub  input  1  present only with ADDER_SUB_EN; 1 = subtract (x - y)

Behaviour:
- Internal state:
  - bit counter `cnt`, width clog2(WIDTH) with minimum 1, range 0..WIDTH-1.
  - carry flop `c`.
- Reset:
  - On a rising clk with rst=1: cnt=0, c=0, out=0, carry_out=0, word_done=0.
  - rst has priority over all other activity, including mid-word.
  - The first bit after reset is bit 0 of a new word.
- Every non-reset rising edge, one bit is processed; there is no enable or stall:
  - cin = 0 if cnt==0, else c.
  - s = x ^ y ^ cin.
  - co = (x&y) | (x&cin) | (y&cin).
  - out <= s (latency 1 cycle from sampling).
  - c <= co.
- Counter:
  - If cnt == WIDTH-1: cnt <= 0, word_done <= 1, carry_out <= co.
  - Otherwise: cnt <= cnt+1, word_done <= 0, carry_out holds its previous value.
- WIDTH=1: every bit is a complete word; word_done is 1 every cycle after reset; cin is always 0.
- The full result of a word is {carry_out, sum bits}, i.e. WIDTH+1 bits; there is no overflow truncation.
- Inputs x/y must be stable at the rising edge; no internal synchronisation.
- All outputs come from flops (no combinational path from input to output).

Optional Feature:
- Macro ADDER_SUB_EN.
- When defined:
  - Port `sub` exists.
  - `sub` is sampled when cnt==0 and latched for the whole word; changing it mid-word has no effect until the next word.
  - With sub latched high: y is inverted before the full adder, and cin at cnt==0 is 1 (two's-complement subtract).
  - carry_out=1 means no borrow (x >= y unsigned).
- When undefined:
  - No `sub` port, no latch.
  - Behaviour is pure addition as above.

Decomposition:
- Package adder_2bit_pkg:
  - default WIDTH constant.
  - counter-width localparam / clog2 helper function.
- One natural sub-module, full_adder_cell: combinational (a, b, cin) -> (s, co).
  - Instantiated once.
  - The top-level holds the counter, carry flop, optional sub latch and output registers.

Test Plan:
- Reset: hold rst=1 for 2 cycles with x=y=1 -> out=0, carry_out=0, word_done=0; first post-reset bit is treated with cin=0.
- 1+1 (x bits 1,0; y bits 1,0) -> out sequence 0,1; word_done on the 2nd output; carry_out=0 (result 2).
- 3+3 (x 1,1; y 1,1) -> out 0,1; carry_out=1 (result 6). The next word 0+0 -> out 0,0, carry_out=0, proving the carry clears at the word boundary.
- Mid-word reset: send bit0 of 3+3, assert rst for one cycle, then 2+1 (x 0,1; y 1,0) -> out 1,1, carry_out=0; no leftover carry.
- Continuous stream: 1+1, then 3+3, then 2+1 back-to-back -> word_done pulses every 2nd cycle; carry_out 0, 1, 0.
- ADDER_SUB_EN with sub=1: 3-1 (x 1,1; y 1,0) -> out 0,1, carry_out=1. Then 1-2 (x 1,0; y 0,1) -> out 1,1 (=3, i.e. -1 mod 4), carry_out=0 (borrow).
